mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive CPU grants with a DMA request pending before DMA is forced to win.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 cpu_req  in  1  processor access request; held with stable fields until cpu_done.
REQ-006 cpu_we  in  1  processor write enable (1 = write).
REQ-007 cpu_adr  in  AW  processor address.
REQ-008 cpu_wd  in  32  processor write data.
REQ-009 cpu_rd  out  32  processor read data; valid while cpu_done = 1.
REQ-010 cpu_done  out  1  one-cycle completion pulse for the processor access.
REQ-011 cpu_stall  out  1  combinational (cpu_req & ~cpu_done); holds the multicycle processor state.
REQ-012 dma_req, dma_we, dma_adr, dma_wd  in  1/1/AW/32  DMA/loader request port; same semantics as the cpu_* inputs.
REQ-013 dma_rd  out  32  DMA read data; valid while dma_done = 1.
REQ-014 dma_done  out  1  one-cycle completion pulse for the DMA access.
REQ-015 mem_req, mem_we  out  1/1  shared single-port memory request and write enable.
REQ-016 mem_adr  out  AW  memory address.
REQ-017 mem_wd  out  32  memory write data.
REQ-018 mem_rd  in  32  memory read data; sampled when mem_ack = 1.
REQ-019 mem_ack  in  1  memory completion; any number of wait cycles, including zero, is allowed.

Function
REQ-020 FSM states: IDLE, CPU_BUSY, DMA_BUSY, CPU_RESP, DMA_RESP.
REQ-021 IDLE, no request: stay in IDLE.
REQ-022 IDLE, request present: latch the winner's we/adr/wd and go to that winner's BUSY state.
REQ-023 Arbitration: CPU wins by default.
REQ-024 Arbitration override: DMA wins when dma_req = 1 and starve_cnt == STARVE_LIMIT.
REQ-025 BUSY state: mem_req = 1 and mem_we/mem_adr/mem_wd driven from the latched registers; these outputs are registered, never combinational from the requester inputs.
REQ-026 BUSY state, mem_ack = 1: capture mem_rd into the owner's rd register and go to the owner's RESP state.
REQ-027 BUSY state, mem_ack = 0: remain in BUSY with all memory outputs stable.
REQ-028 RESP state: owner's done = 1 for exactly one cycle; new requests are not sampled; next state is IDLE.
REQ-029 Latency: request seen in IDLE at cycle N -> mem_req high at N+1 -> with ack at N+1, done at N+2 -> IDLE at N+3.
REQ-030 Throughput: minimum 3 cycles per access.
REQ-031 Outside BUSY: mem_req = 0 and mem_we = 0.
REQ-032 A requester dropping req during BUSY does not abort the access; it completes and done still pulses.
REQ-033 rd registers hold their last captured value until the next capture for that port.
REQ-034 starve_cnt, 3 bits: on a CPU grant with dma_req = 1, increment, saturating at STARVE_LIMIT.
REQ-035 starve_cnt clears on any DMA grant and on a CPU grant with dma_req = 0.
REQ-036 A write returns mem_rd unchanged into rd; requesters ignore rd on writes.
REQ-037 mem_ack outside BUSY is ignored.
REQ-038 Only one of cpu_done and dma_done is ever high in a given cycle.

Reset
REQ-039 reset = 0 forces the state to IDLE immediately, asynchronously.
REQ-040 reset = 0 forces mem_req = 0, mem_we = 0, cpu_done = 0, dma_done = 0, starve_cnt = 0.
REQ-041 reset = 0 forces cpu_rd, dma_rd, mem_adr and mem_wd to 0.
REQ-042 Reset during BUSY abandons the access with no done pulse; after reset release, the first rising edge evaluates IDLE normally.

Verification
REQ-043 CPU read, adr 0x10, mem_rd 0xDEADBEEF, ack on the first BUSY cycle -> mem_req high for 1 cycle, cpu_done at N+2, cpu_rd = 0xDEADBEEF.
REQ-044 CPU and DMA request simultaneously in IDLE, starve_cnt = 0 -> CPU served first, DMA granted in the IDLE following CPU_RESP.
REQ-045 CPU requesting continuously, DMA held pending, STARVE_LIMIT = 4 -> after 4 CPU grants the 5th grant goes to DMA, then starve_cnt = 0.
REQ-046 DMA write, adr 0x20, wd 0x12345678, ack delayed 3 cycles -> mem_we = 1 and mem_adr/mem_wd stable for 4 BUSY cycles, then one dma_done pulse.
REQ-047 Reset asserted during CPU_BUSY -> mem_req = 0 in the same cycle, no cpu_done, state IDLE, starve_cnt = 0.
REQ-048 cpu_req dropped mid-BUSY, ack arrives 2 cycles later -> access completes and cpu_done pulses once.

Source files
------------

// File: rtl/mem_arbiter.sv
// CPU/DMA arbiter for one single-port memory: CPU has priority, DMA is forced through after STARVE_LIMIT CPU grants.
// Grant-to-done is 2 cycles with a zero-wait ack, at least 3 cycles per access; requesters stall (hold fields) until their done pulse.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int AW           = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_adr,
   input  logic [31:0]   cpu_wd,
   output logic [31:0]   cpu_rd,
   output logic          cpu_done,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_adr,
   input  logic [31:0]   dma_wd,
   output logic [31:0]   dma_rd,
   output logic          dma_done,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [31:0]   mem_wd,
   input  logic [31:0]   mem_rd,
   input  logic          mem_ack
);

   typedef enum logic [2:0] {IDLE, CPU_BUSY, DMA_BUSY, CPU_RESP, DMA_RESP} state_t;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_t     state, state_nxt;
   logic [2:0] starve_cnt;
   logic       dma_win;

   // DMA only overrides a requesting CPU once it has been passed over LIMIT times
   always_comb begin
      dma_win = dma_req & (~cpu_req | (starve_cnt >= LIMIT));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (dma_win)      state_nxt = DMA_BUSY;
            else if (cpu_req) state_nxt = CPU_BUSY;
         end
         CPU_BUSY: if (mem_ack) state_nxt = CPU_RESP;
         DMA_BUSY: if (mem_ack) state_nxt = DMA_RESP;
         CPU_RESP: state_nxt = IDLE;
         DMA_RESP: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_adr    <= '0;
         mem_wd     <= '0;
         cpu_rd     <= '0;
         dma_rd     <= '0;
         starve_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (dma_win) begin
                  mem_req    <= 1'b1;
                  mem_we     <= dma_we;
                  mem_adr    <= dma_adr;
                  mem_wd     <= dma_wd;
                  starve_cnt <= '0;
               end else if (cpu_req) begin
                  mem_req <= 1'b1;
                  mem_we  <= cpu_we;
                  mem_adr <= cpu_adr;
                  mem_wd  <= cpu_wd;
                  if (!dma_req)                starve_cnt <= '0;
                  else if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 3'd1;
               end
            end
            CPU_BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  cpu_rd  <= mem_rd;
               end
            end
            DMA_BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  dma_rd  <= mem_rd;
               end
            end
            default: ;
         endcase
      end
   end

   assign cpu_done  = (state == CPU_RESP);
   assign dma_done  = (state == DMA_RESP);
   assign cpu_stall = cpu_req & ~cpu_done;

endmodule
